// File: rtl/bcd_pkg.sv
// bcd_pkg: shared digit type, double-dabble constants, sizing helper and FSM states
package bcd_pkg;
    typedef logic [3:0] digit_t;
    localparam digit_t BCD_ADD3 = 4'd3;
    localparam digit_t BCD_THRESH = 4'd5;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    // Smallest digit count d with 10^d >= 2^width, i.e. enough for 2^width-1
    function automatic int min_digits(input int width);
        logic [255:0] pow;
        logic [255:0] lim;
        int d;
        pow = 256'd1;
        lim = 256'd1 << width;
        d = 0;
        while (pow < lim) begin
            pow = pow * 256'd10;
            d++;
        end
        return (d < 1) ? 1 : d;
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: single-digit double-dabble corrector, adds 3 when the digit is 5 or more
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  digit_t d,
    output digit_t q
);
    assign q = (d >= BCD_THRESH) ? d + BCD_ADD3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble binary to BCD converter with
// valid/ready on both sides and a significant-digit count for leading-zero blanking
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGITS = 3,
    localparam int CW = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic [CW-1:0]       sig_digits
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int NW = $clog2(WIDTH + 1);

    if (DIGITS < min_digits(WIDTH)) begin : g_chk
        $fatal(1, "bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    state_t          state;
    logic [SW-1:0]   sr;
    logic [NW-1:0]   cnt;
    logic [BW-1:0]   adj_bcd;
    logic [SW-1:0]   nxt;
    logic [CW-1:0]   sig_nxt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (.d(sr[WIDTH+4*i +: 4]), .q(adj_bcd[4*i +: 4]));
    end

    // The corrected top bit is always zero for a legal DIGITS, so dropping it is safe
    assign nxt = SW'({adj_bcd, sr[WIDTH-1:0]} << 1);

    always_comb begin
        sig_nxt = CW'(1);
        for (int k = 0; k < DIGITS; k++)
            if (nxt[WIDTH+4*k +: 4] != 4'd0) sig_nxt = CW'(k + 1);
    end

    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            bcd <= '0;
            sig_digits <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr <= SW'(bin);
                    cnt <= NW'(WIDTH);
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr <= nxt;
                    cnt <= cnt - NW'(1);
                    if (cnt == NW'(1)) begin
                        state <= DONE;
                        bcd <= nxt[SW-1:WIDTH];
                        sig_digits <= sig_nxt;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of the default 8/3 converter and a 16/5 instance
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv_a = 1'b0, or_a = 1'b0, ir_a, ov_a;
    logic [7:0] bin_a = '0;
    logic [11:0] bcd_a;
    logic [1:0] sig_a;
    logic iv_b = 1'b0, or_b = 1'b0, ir_b, ov_b;
    logic [15:0] bin_b = '0;
    logic [19:0] bcd_b;
    logic [2:0] sig_b;
    int total = 0;
    int bad = 0;
    int lat;

    always #5 clk = ~clk;

    bin_to_bcd_seq u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .bin(bin_a),
        .out_valid(ov_a), .out_ready(or_a), .bcd(bcd_a), .sig_digits(sig_a)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .bin(bin_b),
        .out_valid(ov_b), .out_ready(or_b), .bcd(bcd_b), .sig_digits(sig_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ref3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] refsig(input int v);
        return (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    endfunction

    task automatic conv_a(input logic [7:0] v, output int l);
        bin_a = v;
        iv_a = 1'b1;
        tick();
        iv_a = 1'b0;
        bin_a = ~v;
        l = 0;
        while (!ov_a && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic pop_a();
        or_a = 1'b1;
        tick();
        or_a = 1'b0;
    endtask

    task automatic conv_b(input logic [15:0] v, output int l);
        bin_b = v;
        iv_b = 1'b1;
        tick();
        iv_b = 1'b0;
        l = 0;
        while (!ov_b && l < 60) begin
            tick();
            l++;
        end
    endtask

    initial begin
        #2;
        check("rst_in_ready", 32'(ir_a), 1);
        check("rst_out_valid", 32'(ov_a), 0);
        check("rst_bcd", 32'(bcd_a), 0);
        check("rst_sig", 32'(sig_a), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        conv_a(8'd255, lat);
        check("t1_latency", 32'(lat), 8);
        check("t1_bcd", 32'(bcd_a), 32'h255);
        check("t1_sig", 32'(sig_a), 3);
        check("t1_in_ready_low", 32'(ir_a), 0);
        pop_a();
        check("t1_pop_out_valid", 32'(ov_a), 0);

        conv_a(8'd0, lat);
        check("t2_0_bcd", 32'(bcd_a), 32'h000);
        check("t2_0_sig", 32'(sig_a), 1);
        pop_a();
        conv_a(8'd9, lat);
        check("t2_9_bcd", 32'(bcd_a), 32'h009);
        check("t2_9_sig", 32'(sig_a), 1);
        pop_a();
        conv_a(8'd10, lat);
        check("t2_10_bcd", 32'(bcd_a), 32'h010);
        check("t2_10_sig", 32'(sig_a), 2);
        pop_a();
        conv_a(8'd100, lat);
        check("t2_100_bcd", 32'(bcd_a), 32'h100);
        check("t2_100_sig", 32'(sig_a), 3);
        pop_a();

        conv_a(8'd173, lat);
        check("t3_latency", 32'(lat), 8);
        for (int c = 0; c < 20; c++) begin
            iv_a = (c % 4 == 0);
            bin_a = 8'd42;
            tick();
            check("t3_hold_valid", 32'(ov_a), 1);
            check("t3_hold_bcd", 32'(bcd_a), 32'h173);
            check("t3_hold_sig", 32'(sig_a), 3);
        end
        iv_a = 1'b0;
        pop_a();
        check("t3_in_ready_after_pop", 32'(ir_a), 1);
        check("t3_out_valid_after_pop", 32'(ov_a), 0);
        conv_a(8'd42, lat);
        check("t3_42_bcd", 32'(bcd_a), 32'h042);
        check("t3_42_sig", 32'(sig_a), 2);
        pop_a();

        bin_a = 8'd200;
        iv_a = 1'b1;
        tick();
        iv_a = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t4_abort_out_valid", 32'(ov_a), 0);
        check("t4_abort_bcd", 32'(bcd_a), 0);
        check("t4_abort_sig", 32'(sig_a), 0);
        check("t4_abort_in_ready", 32'(ir_a), 1);
        tick();
        rst = 1'b0;
        tick();
        conv_a(8'd200, lat);
        check("t4_latency", 32'(lat), 8);
        check("t4_200_bcd", 32'(bcd_a), 32'h200);
        pop_a();

        conv_b(16'd65535, lat);
        check("t5_latency", 32'(lat), 16);
        check("t5_65535_bcd", 32'(bcd_b), 32'h65535);
        check("t5_65535_sig", 32'(sig_b), 5);
        or_b = 1'b1;
        tick();
        or_b = 1'b0;
        conv_b(16'd1000, lat);
        check("t5_1000_bcd", 32'(bcd_b), 32'h01000);
        check("t5_1000_sig", 32'(sig_b), 4);
        or_b = 1'b1;
        tick();
        or_b = 1'b0;

        for (int v = 0; v < 256; v++) begin
            int stall;
            conv_a(8'(v), lat);
            check("t6_latency", 32'(lat), 8);
            stall = int'($urandom_range(3, 0));
            for (int s = 0; s < stall; s++) begin
                tick();
                check("t6_stall_valid", 32'(ov_a), 1);
            end
            check("t6_bcd", 32'(bcd_a), 32'(ref3(v)));
            check("t6_sig", 32'(sig_a), refsig(v));
            pop_a();
            check("t6_no_dup", 32'(ov_a), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock. It is the area-lean successor to the combinational 8-bit/3-digit converter and is generalised to any WIDTH/DIGITS pair. Valid/ready handshakes on both sides. It also reports the significant-digit count so display drivers can blank leading zeros. It sits between arithmetic/counter blocks and the 7-segment display multiplexer.

Parameters:
WIDTH, 8, binary input width in bits (≥1).
DIGITS, 3, BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH−1; checked at elaboration (fatal otherwise).
CW, $clog2(DIGITS+1), width of sig_digits (localparam, not overridable).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  input word offered.
in_ready  out  1  converter idle; high when able to accept.
bin  in  WIDTH  unsigned binary value, sampled only on accept.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
bcd  out  4*DIGITS  packed BCD; digit 0 (units) at bcd[3:0], digit k at bcd[4k+3:4k].
sig_digits  out  CW  index of the most significant non-zero digit + 1; value is 1 when bin=0.

Behaviour:
- Reset (async assert, sync-release assumed upstream): state=IDLE, shift register=0, bit counter=0, out_valid=0, bcd=0, sig_digits=0. in_ready=1 while in IDLE, including during reset.
- Internal shift register is 4*DIGITS+WIDTH bits, {bcd_field, bin_field}. Bit counter is $clog2(WIDTH+1) bits.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid=1 (accept edge), load {0, bin}, counter=WIDTH, go to SHIFT. Otherwise hold.
- SHIFT, once per clock:
  - For every digit whose pre-shift value is ≥5, add 3 to it. All digits are corrected in parallel from the same pre-shift snapshot.
  - Shift the whole register left by 1; counter−1.
  - When the counter reaches 0 after this shift (i.e. the WIDTH-th shift), go to DONE.
- DONE entry: bcd and sig_digits are registered from the final BCD field on the same edge that enters DONE, and held stable until handshake completion.
- Latency: out_valid rises exactly WIDTH clocks after the accept edge (8 for default).
- DONE: hold outputs while out_ready=0. On out_ready=1, go to IDLE; out_valid drops next cycle.
- Throughput: one conversion per WIDTH+2 cycles minimum. There is no same-cycle result-pop-and-accept: in_ready is 0 in the cycle the result is popped.
- in_valid in SHIFT/DONE is ignored, with no effect. bin changes after accept have no effect.
- sig_digits: scan digits from DIGITS−1 downward. Value = highest index k with digit≠0, plus 1; value = 1 if all digits are zero.
- Every digit of bcd is always ≤9. Unused leading digits read 0.
- Reset mid-SHIFT or mid-DONE: conversion is aborted, all outputs return to reset values immediately, and no partial result is ever presented.
- WIDTH=1 is legal: one shift, latency 1.

Decomposition:
- Shared package bcd_pkg: digit type (4-bit), constant BCD_ADD3=4'd3, constant BCD_THRESH=4'd5, function min_digits(width) for elaboration checks, and the FSM state enum.
- One natural sub-module: bcd_digit_adj. It is a combinational per-digit ≥5 → +3 corrector, instantiated DIGITS times via generate. It is reusable by the display-block counters.

Test Plan:
1. Defaults: bin=8'd255, in_valid pulse → out_valid exactly 8 cycles after accept; bcd=12'h255, sig_digits=3.
2. bin=0 → bcd=12'h000, sig_digits=1. bin=9 → 12'h009, sig_digits=1. bin=10 → 12'h010, sig_digits=2. bin=100 → 12'h100, sig_digits=3.
3. Backpressure: out_ready=0 for 20 cycles after bin=173 → bcd=12'h173 held stable and out_valid high throughout; in_valid pulses with bin=42 during the hold are ignored. After out_ready=1, in_ready rises next cycle; then bin=42 → 12'h042.
4. Reset mid-conversion: assert rst at cycle 4 of SHIFT for bin=200 → out_valid=0, bcd=0, in_ready=1 immediately. After release, bin=200 converts cleanly to 12'h200.
5. Parametrised instance WIDTH=16, DIGITS=5: bin=65535 → bcd=20'h65535 after 16 cycles, sig_digits=5. bin=1000 → 20'h01000, sig_digits=4.
6. Exhaustive sweep at defaults: all 0..255 back-to-back with random out_ready stalls → every result matches the reference model value/100, (value/10)%10, value%10, plus sig_digits; no dropped or duplicated transactions.
